// File: rtl/tmds_period_scheduler.sv
// Per-pixel-clock word scheduler for the three TMDS channels: control, preamble, guard band or video.
// Build with HDMI_PREAMBLE_EN defined for HDMI data-island framing; undefined gives plain DVI (CTRL/VIDEO only).
module tmds_period_scheduler #(
    parameter int PRE_LEN = 8,
    parameter int GB_LEN  = 2
) (
    input  logic       paralell_clk,
    input  logic       reset,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] enc0_in,
    input  logic [9:0] enc1_in,
    input  logic [9:0] enc2_in,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic [1:0] period,
    output logic       short_gap_err
);

    localparam int D  = PRE_LEN + GB_LEN;
    localparam int GW = $clog2(D + 1);

    localparam logic [9:0] TOK_00   = 10'b1101010100;
    localparam logic [9:0] TOK_01   = 10'b0010101011;
    localparam logic [9:0] TOK_10   = 10'b0101010100;
    localparam logic [9:0] TOK_11   = 10'b1010101011;
    localparam logic [9:0] GUARD_02 = 10'b1011001100;
    localparam logic [9:0] GUARD_1  = 10'b0100110011;

    typedef enum logic [1:0] {
        ST_CTRL  = 2'd0,
        ST_PRE   = 2'd1,
        ST_GUARD = 2'd2,
        ST_VIDEO = 2'd3
    } state_t;

    // Stage layout: {de, vs, hs, enc2, enc1, enc0}
    logic [32:0] pipe_r [D];
    logic [32:0] dly_s;
    logic        de_d_s;
    logic        acc_edge_s;
    logic        short_edge_s;
    state_t      state_r;
    state_t      nxt_s;
    logic [3:0]  cnt_r;

    function automatic logic [9:0] ctl_token(input logic [1:0] ctl);
        logic [9:0] w;
        case (ctl)
            2'b00:   w = TOK_00;
            2'b01:   w = TOK_01;
            2'b10:   w = TOK_10;
            2'b11:   w = TOK_11;
            default: w = TOK_00;
        endcase
        return w;
    endfunction

    // Returns {ch2, ch1, ch0} for the given output period and delayed stream slot.
    function automatic logic [29:0] sel_words(input state_t st, input logic [32:0] d);
        logic [29:0] w;
        case (st)
            ST_CTRL:  w = {TOK_00, TOK_00, ctl_token(d[31:30])};
            ST_PRE:   w = {TOK_00, TOK_01, ctl_token(d[31:30])};
            ST_GUARD: w = {GUARD_02, GUARD_1, GUARD_02};
            ST_VIDEO: w = d[29:0];
            default:  w = {TOK_00, TOK_00, TOK_00};
        endcase
        return w;
    endfunction

    // Lookahead delay line; the output register adds the final clock of latency.
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                pipe_r[i] <= 33'd0;
            end
        end else begin
            pipe_r[0] <= {de_in, vsync_in, hsync_in, enc2_in, enc1_in, enc0_in};
            for (int i = 1; i < D; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dly_s  = pipe_r[D-1];
    assign de_d_s = dly_s[32];

`ifdef HDMI_PREAMBLE_EN
    logic          de_prev_r;
    logic [GW-1:0] gap_r;
    logic          rise_s;

    // Blank-gap length at the input, saturating at the lookahead depth.
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            de_prev_r <= 1'b0;
            gap_r     <= '0;
        end else begin
            de_prev_r <= de_in;
            if (de_in) begin
                gap_r <= '0;
            end else if (gap_r != GW'(D)) begin
                gap_r <= gap_r + GW'(1);
            end else begin
                gap_r <= gap_r;
            end
        end
    end

    assign rise_s       = de_in & ~de_prev_r;
    assign acc_edge_s   = rise_s & (gap_r == GW'(D));
    assign short_edge_s = rise_s & (gap_r != GW'(D));
`else
    assign acc_edge_s   = 1'b0;
    assign short_edge_s = 1'b0;
`endif

    // Next output period. An accepted edge can only arrive once the delay line holds
    // a full blank gap, so de_d_s is already 0 when it is taken from VIDEO.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_CTRL: begin
                if (acc_edge_s) begin
                    nxt_s = ST_PRE;
                end else if (de_d_s) begin
                    nxt_s = ST_VIDEO;
                end else begin
                    nxt_s = ST_CTRL;
                end
            end
            ST_PRE: begin
                if (cnt_r == 4'd0) begin
                    nxt_s = ST_GUARD;
                end else begin
                    nxt_s = ST_PRE;
                end
            end
            ST_GUARD: begin
                if (cnt_r == 4'd0) begin
                    nxt_s = ST_VIDEO;
                end else begin
                    nxt_s = ST_GUARD;
                end
            end
            ST_VIDEO: begin
                if (acc_edge_s) begin
                    nxt_s = ST_PRE;
                end else if (!de_d_s) begin
                    nxt_s = ST_CTRL;
                end else begin
                    nxt_s = ST_VIDEO;
                end
            end
            default: nxt_s = ST_CTRL;
        endcase
    end

    // Period FSM, run-length counter and registered serializer words.
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            state_r       <= ST_CTRL;
            cnt_r         <= 4'd0;
            tmds_ch0      <= TOK_00;
            tmds_ch1      <= TOK_00;
            tmds_ch2      <= TOK_00;
            short_gap_err <= 1'b0;
        end else begin
            state_r       <= nxt_s;
            short_gap_err <= short_edge_s;
            {tmds_ch2, tmds_ch1, tmds_ch0} <= sel_words(nxt_s, dly_s);
            if ((nxt_s == ST_PRE) && (state_r != ST_PRE)) begin
                cnt_r <= 4'(PRE_LEN - 1);
            end else if ((nxt_s == ST_GUARD) && (state_r != ST_GUARD)) begin
                cnt_r <= 4'(GB_LEN - 1);
            end else if (cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign period = state_r;

endmodule
